// File: rtl/mem_frame_reader_pkg.sv
// Shared constants and types for the packet SRAM bank writer and reader:
// region map, descriptor layout, reader FSM states and the per-word tag.
package mem_frame_reader_pkg;

   localparam int pDEPTH_RAM = 4608;
   localparam int pADDR_W    = $clog2(pDEPTH_RAM);
   localparam int pRD_LAT    = 2;
   localparam int pSKID      = 4;

   localparam logic [pADDR_W-1:0] R0_BASE = pADDR_W'(0);
   localparam logic [pADDR_W-1:0] R0_TOP  = pADDR_W'(1534);
   localparam logic [pADDR_W-1:0] R1_BASE = pADDR_W'(1535);
   localparam logic [pADDR_W-1:0] R1_TOP  = pADDR_W'(3070);
   localparam logic [pADDR_W-1:0] R2_BASE = pADDR_W'(3071);
   localparam logic [pADDR_W-1:0] R2_TOP  = pADDR_W'(pDEPTH_RAM - 1);

   localparam int DESC_START_LSB = 0;
   localparam int DESC_END_LSB   = pADDR_W;
   localparam int DESC_EXTRA_LSB = 2 * pADDR_W;
   localparam int DESC_W         = 2 * pADDR_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_LOAD = 2'd2,
      ST_READ = 2'd3
   } rd_state_t;

   typedef struct packed {
      logic       sof;
      logic       eof;
      logic [1:0] extra;
   } tag_t;

   function automatic logic [1:0] region_of(input logic [pADDR_W-1:0] adr);
      if (adr <= R0_TOP)      return 2'd0;
      else if (adr <= R1_TOP) return 2'd1;
      else                    return 2'd2;
   endfunction

   function automatic logic [pADDR_W-1:0] region_base(input logic [1:0] rgn);
      case (rgn)
         2'd0:    return R0_BASE;
         2'd1:    return R1_BASE;
         default: return R2_BASE;
      endcase
   endfunction

   function automatic logic [pADDR_W-1:0] region_top(input logic [1:0] rgn);
      case (rgn)
         2'd0:    return R0_TOP;
         2'd1:    return R1_TOP;
         default: return R2_TOP;
      endcase
   endfunction

endpackage

// File: rtl/mem_frame_reader_if.sv
// Reader-side bundle: descriptor FIFO pop, SRAM read port, egress stream, region release.
// Names are from the reader's view; master = the reader, slave = everything around it.
interface mem_frame_reader_if;
   import mem_frame_reader_pkg::*;

   logic                i_fifo_empty;
   logic                o_fifo_rd;
   logic [DESC_W-1:0]   i_fifo_data;
   logic [pADDR_W-1:0]  o_adr_out;
   logic                o_en_read;
   logic [31:0]         i_mem_data;
   logic [31:0]         o_data;
   logic                o_valid;
   logic                i_ready;
   logic                o_sof;
   logic                o_eof;
   logic [1:0]          o_last_bytes;
   logic                o_rel_valid;
   logic [1:0]          o_rel_region;
   logic [pADDR_W-1:0]  o_rel_adr;
   logic                o_err;

   modport master (
      input  i_fifo_empty, i_fifo_data, i_mem_data, i_ready,
      output o_fifo_rd, o_adr_out, o_en_read, o_data, o_valid, o_sof, o_eof,
             o_last_bytes, o_rel_valid, o_rel_region, o_rel_adr, o_err
   );

   modport slave (
      output i_fifo_empty, i_fifo_data, i_mem_data, i_ready,
      input  o_fifo_rd, o_adr_out, o_en_read, o_data, o_valid, o_sof, o_eof,
             o_last_bytes, o_rel_valid, o_rel_region, o_rel_adr, o_err
   );
endinterface

// File: rtl/mem_frame_reader_skid_fifo.sv
// Small synchronous FIFO with occupancy count; data readable at the head while count != 0.
// Push when full and pop when empty are ignored; i_reset flushes the pointers.
module mem_rd_skid_fifo #(
   parameter int pDEPTH = 4,
   parameter int pWIDTH = 36,
   localparam int CW    = $clog2(pDEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic [pWIDTH-1:0] i_din,
   input  logic              i_pop,
   output logic [pWIDTH-1:0] o_dout,
   output logic [CW-1:0]     o_count
);
   localparam int PW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

   logic [pWIDTH-1:0] r_mem [pDEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != CW'(pDEPTH)) || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= (r_wr_ptr == PW'(pDEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(pDEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;
endmodule

// File: rtl/mem_frame_reader.sv
// Pops frame descriptors, reads the frame's words from the 3-region SRAM (read latency pRD_LAT),
// and streams them through a credit-limited skid FIFO; egress stalls on i_ready, releasing a region on eof pop.
module mem_frame_reader
   import mem_frame_reader_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   mem_frame_reader_if.master bus
);
   localparam int CW     = $clog2(pSKID + 1);
   localparam int SKID_W = 32 + $bits(tag_t);
   localparam int REL_W  = 2 + pADDR_W;

   rd_state_t          r_state, w_next;
   logic [pADDR_W-1:0] r_cur, r_end, w_cur_next;
   logic [1:0]         r_extra, r_region;
   logic               r_first;
   logic [CW-1:0]      r_outst;
   logic [pRD_LAT-1:0] r_tag_vld;
   tag_t               r_tag [pRD_LAT];

   logic [pADDR_W-1:0] w_ld_start, w_ld_end;
   logic [1:0]         w_ld_extra, w_ld_region;
   logic               w_ld_bad;
   logic               w_credit, w_eof_now, w_issue, w_fifo_rd, w_err, w_arrive;
   logic [CW-1:0]      w_sk_count, w_rel_count;
   logic [SKID_W-1:0]  w_sk_dout;
   logic [REL_W-1:0]   w_rel_dout;
   tag_t               w_sk_tag;
   logic               w_sk_vld, w_pop;

   assign w_ld_start  = bus.i_fifo_data[DESC_START_LSB +: pADDR_W];
   assign w_ld_end    = bus.i_fifo_data[DESC_END_LSB +: pADDR_W];
   assign w_ld_extra  = bus.i_fifo_data[DESC_EXTRA_LSB +: 2];
   assign w_ld_region = region_of(w_ld_start);
   assign w_ld_bad    = (w_ld_start >= pADDR_W'(pDEPTH_RAM)) || (w_ld_end >= pADDR_W'(pDEPTH_RAM))
                     || (region_of(w_ld_end) != w_ld_region);

   // Everything issued but not yet popped on egress must fit in the skid FIFO.
   assign w_credit   = ({1'b0, r_outst} + {1'b0, w_sk_count}) < (CW + 1)'(pSKID);
   assign w_eof_now  = (r_cur == r_end);
   assign w_cur_next = (r_cur == region_top(r_region)) ? region_base(r_region) : r_cur + 1'b1;

   always_comb begin
      w_next    = r_state;
      w_issue   = 1'b0;
      w_fifo_rd = 1'b0;
      w_err     = 1'b0;
      if (!i_reset) begin
         case (r_state)
            ST_IDLE: if (!bus.i_fifo_empty) w_next = ST_POP;
            ST_POP: begin
               w_fifo_rd = 1'b1;
               w_next    = ST_LOAD;
            end
            ST_LOAD: begin
               if (w_ld_bad) begin
                  w_err  = 1'b1;
                  w_next = ST_IDLE;
               end else begin
                  w_next = ST_READ;
               end
            end
            ST_READ: begin
               if (w_credit) begin
                  w_issue = 1'b1;
                  if (w_eof_now) w_next = bus.i_fifo_empty ? ST_IDLE : ST_POP;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_cur    <= '0;
         r_end    <= '0;
         r_extra  <= '0;
         r_region <= '0;
         r_first  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_LOAD) begin
            r_cur    <= w_ld_start;
            r_end    <= w_ld_end;
            r_extra  <= w_ld_extra;
            r_region <= w_ld_region;
            r_first  <= 1'b1;
         end else if (w_issue) begin
            r_cur   <= w_cur_next;
            r_first <= 1'b0;
         end
      end
   end

   // Tags travel alongside the SRAM read so they line up with i_mem_data.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tag_vld <= '0;
         r_outst   <= '0;
         for (int i = 0; i < pRD_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag_vld[0] <= w_issue;
         r_tag[0]     <= '{sof: r_first, eof: w_eof_now, extra: r_extra};
         for (int i = 1; i < pRD_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag[i]     <= r_tag[i-1];
         end
         if (w_issue && !w_arrive)      r_outst <= r_outst + 1'b1;
         else if (!w_issue && w_arrive) r_outst <= r_outst - 1'b1;
      end
   end

   assign w_arrive = r_tag_vld[pRD_LAT-1];

   mem_rd_skid_fifo #(.pDEPTH(pSKID), .pWIDTH(SKID_W)) u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_arrive),
      .i_din   ({bus.i_mem_data, r_tag[pRD_LAT-1]}),
      .i_pop   (w_pop),
      .o_dout  (w_sk_dout),
      .o_count (w_sk_count)
   );

   // Region/end of every frame whose eof read is issued but not yet popped.
   mem_rd_skid_fifo #(.pDEPTH(pSKID), .pWIDTH(REL_W)) u_rel (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_issue && w_eof_now),
      .i_din   ({r_region, r_end}),
      .i_pop   (w_pop && w_sk_tag.eof),
      .o_dout  (w_rel_dout),
      .o_count (w_rel_count)
   );

   assign w_sk_vld = (w_sk_count != '0);
   assign w_sk_tag = tag_t'(w_sk_dout[$bits(tag_t)-1:0]);
   assign w_pop    = w_sk_vld && bus.i_ready;

   assign bus.o_fifo_rd    = w_fifo_rd;
   assign bus.o_en_read    = w_issue;
   assign bus.o_adr_out    = w_issue ? r_cur : '0;
   assign bus.o_err        = w_err;
   assign bus.o_valid      = w_sk_vld;
   assign bus.o_data       = w_sk_vld ? w_sk_dout[SKID_W-1 -: 32] : '0;
   assign bus.o_sof        = w_sk_vld && w_sk_tag.sof;
   assign bus.o_eof        = w_sk_vld && w_sk_tag.eof;
   assign bus.o_last_bytes = (w_sk_vld && w_sk_tag.eof) ? w_sk_tag.extra : 2'd0;
   assign bus.o_rel_valid  = w_pop && w_sk_tag.eof && (w_rel_count != '0);
   assign bus.o_rel_region = bus.o_rel_valid ? w_rel_dout[REL_W-1 -: 2] : 2'd0;
   assign bus.o_rel_adr    = bus.o_rel_valid ? w_rel_dout[pADDR_W-1:0] : '0;
endmodule

// File: tb/tb_mem_frame_reader.sv
// Bench for mem_frame_reader: descriptor FIFO and 2-cycle SRAM models, egress monitor,
// vector table for single frames plus directed backpressure, back-to-back and reset sequences.
module tb_mem_frame_reader;
   import mem_frame_reader_pkg::*;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;
   always #5 i_clk = ~i_clk;

   mem_frame_reader_if bus ();

   mem_frame_reader dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   function automatic logic [31:0] pat(input logic [pADDR_W-1:0] a);
      return 32'hA500_0000 | {19'd0, a};
   endfunction

   // descriptor FIFO model: data appears the cycle after o_fifo_rd
   logic [DESC_W-1:0] dq [32];
   logic [4:0]        dq_wr = 5'd0;
   logic [4:0]        dq_rd = 5'd0;
   assign bus.i_fifo_empty = (dq_wr == dq_rd);
   always @(posedge i_clk) begin
      if (bus.o_fifo_rd && (dq_wr != dq_rd)) begin
         bus.i_fifo_data <= dq[dq_rd];
         dq_rd           <= dq_rd + 5'd1;
      end
   end

   // SRAM model: bank input register then array read
   logic [pADDR_W-1:0] m_adr = '0;
   logic               m_vld = 1'b0;
   always @(posedge i_clk) begin
      m_adr          <= bus.o_adr_out;
      m_vld          <= bus.o_en_read;
      bus.i_mem_data <= m_vld ? pat(m_adr) : 32'hDEAD_BEEF;
   end

   typedef struct packed {
      logic [31:0] d;
      logic        sof;
      logic        eof;
      logic [1:0]  lb;
   } word_t;

   logic [pADDR_W-1:0] iss_adr [256];
   int                 iss_cyc [256];
   word_t              words   [256];
   logic [1:0]         rel_rgn [64];
   logic [pADDR_W-1:0] rel_adr [64];
   int n_iss = 0, n_word = 0, n_rel = 0, n_err = 0, cyc = 0;
   int max_infl = 0, stall_viol = 0;
   logic p_vld = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
   logic [31:0] p_dat = '0;

   always @(negedge i_clk) begin
      if (bus.o_en_read) begin
         iss_adr[n_iss] = bus.o_adr_out;
         iss_cyc[n_iss] = cyc;
         n_iss++;
      end
      if (bus.o_valid && bus.i_ready) begin
         words[n_word] = '{d: bus.o_data, sof: bus.o_sof, eof: bus.o_eof, lb: bus.o_last_bytes};
         n_word++;
      end
      if (n_iss - n_word > max_infl) max_infl = n_iss - n_word;
      if (p_vld && !p_rdy && !p_rst && (!bus.o_valid || bus.o_data != p_dat)) stall_viol++;
      p_vld = bus.o_valid;
      p_rdy = bus.i_ready;
      p_rst = i_reset;
      p_dat = bus.o_data;
      if (bus.o_rel_valid) begin
         rel_rgn[n_rel] = bus.o_rel_region;
         rel_adr[n_rel] = bus.o_rel_adr;
         n_rel++;
      end
      if (bus.o_err) n_err++;
      cyc++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic push_desc(input logic [pADDR_W-1:0] st, input logic [pADDR_W-1:0] en,
                            input logic [1:0] ex);
      dq[dq_wr] = {ex, en, st};
      dq_wr     = dq_wr + 5'd1;
   endtask

   task automatic wait_until(input int tgt_rel, input int tgt_err, input string nm);
      int t = 0;
      while (n_rel < tgt_rel && n_err < tgt_err && t < 400) begin
         tick(1);
         t++;
      end
      chk({nm, " timeout"}, 64'(t >= 400), 64'd0);
      tick(3);
   endtask

   typedef struct {
      logic [pADDR_W-1:0] st;
      logic [pADDR_W-1:0] en;
      logic [1:0]         ex;
      int                 len;
      logic [1:0]         rgn;
      logic [pADDR_W-1:0] base;
      logic [pADDR_W-1:0] top;
      bit                 err;
   } vec_t;

   vec_t vt [6];

   initial begin
      int b_iss, b_word, b_rel, b_err;
      logic [pADDR_W-1:0] a;
      word_t w;

      vt[0] = '{13'd5,    13'd9,    2'd0, 5, 2'd0, 13'd0,    13'd1534, 1'b0};
      vt[1] = '{13'd3069, 13'd1536, 2'd3, 4, 2'd1, 13'd1535, 13'd3070, 1'b0};
      vt[2] = '{13'd3071, 13'd3071, 2'd1, 1, 2'd2, 13'd3071, 13'd4607, 1'b0};
      vt[3] = '{13'd10,   13'd2000, 2'd0, 0, 2'd0, 13'd0,    13'd1534, 1'b1};
      vt[4] = '{13'd4606, 13'd3072, 2'd2, 4, 2'd2, 13'd3071, 13'd4607, 1'b0};
      vt[5] = '{13'd1534, 13'd0,    2'd0, 2, 2'd0, 13'd0,    13'd1534, 1'b0};

      bus.i_ready = 1'b1;
      tick(3);
      i_reset = 1'b0;
      chk("reset outputs",
          64'({bus.o_valid, bus.o_en_read, bus.o_fifo_rd, bus.o_rel_valid, bus.o_err,
               bus.o_sof, bus.o_eof, bus.o_last_bytes, bus.o_data, bus.o_adr_out}), 64'd0);
      chk("reset state", 64'(dut.r_state), 64'(ST_IDLE));

      for (int v = 0; v < 6; v++) begin
         b_iss = n_iss; b_word = n_word; b_rel = n_rel; b_err = n_err;
         push_desc(vt[v].st, vt[v].en, vt[v].ex);
         wait_until(b_rel + 1, b_err + 1, $sformatf("v%0d", v));
         chk($sformatf("v%0d reads", v), 64'(n_iss - b_iss), 64'(vt[v].len));
         chk($sformatf("v%0d words", v), 64'(n_word - b_word), 64'(vt[v].len));
         chk($sformatf("v%0d releases", v), 64'(n_rel - b_rel), vt[v].err ? 64'd0 : 64'd1);
         chk($sformatf("v%0d errs", v), 64'(n_err - b_err), vt[v].err ? 64'd1 : 64'd0);
         a = vt[v].st;
         for (int i = 0; i < vt[v].len; i++) begin
            w = words[b_word + i];
            chk($sformatf("v%0d adr%0d", v, i), 64'(iss_adr[b_iss + i]), 64'(a));
            chk($sformatf("v%0d data%0d", v, i), 64'(w.d), 64'(pat(a)));
            chk($sformatf("v%0d sof%0d", v, i), 64'(w.sof), 64'(i == 0));
            chk($sformatf("v%0d eof%0d", v, i), 64'(w.eof), 64'(i == vt[v].len - 1));
            chk($sformatf("v%0d lb%0d", v, i), 64'(w.lb),
                (i == vt[v].len - 1) ? 64'(vt[v].ex) : 64'd0);
            a = (a == vt[v].top) ? vt[v].base : a + 13'd1;
         end
         if (vt[v].len > 0)
            chk($sformatf("v%0d issue span", v),
                64'(iss_cyc[b_iss + vt[v].len - 1] - iss_cyc[b_iss]), 64'(vt[v].len - 1));
         if (!vt[v].err) begin
            chk($sformatf("v%0d rel region", v), 64'(rel_rgn[b_rel]), 64'(vt[v].rgn));
            chk($sformatf("v%0d rel adr", v), 64'(rel_adr[b_rel]), 64'(vt[v].en));
         end
      end

      // backpressure: 20 words, egress stalled 10 cycles mid-frame
      b_iss = n_iss; b_word = n_word; b_rel = n_rel; b_err = n_err;
      push_desc(13'd100, 13'd119, 2'd2);
      for (int t = 0; t < 50 && (n_word - b_word) < 3; t++) tick(1);
      bus.i_ready = 1'b0;
      tick(10);
      bus.i_ready = 1'b1;
      wait_until(b_rel + 1, b_err + 1, "bp");
      chk("bp reads", 64'(n_iss - b_iss), 64'd20);
      chk("bp words", 64'(n_word - b_word), 64'd20);
      for (int i = 0; i < 20; i++) begin
         w = words[b_word + i];
         chk($sformatf("bp data%0d", i), 64'(w.d), 64'(pat(13'(100 + i))));
         chk($sformatf("bp flags%0d", i), 64'({w.sof, w.eof, w.lb}),
             64'({i == 0, i == 19, (i == 19) ? 2'd2 : 2'd0}));
      end
      chk("bp max in flight", 64'(max_infl), 64'(pSKID));
      chk("bp stall hold", 64'(stall_viol), 64'd0);
      chk("bp rel adr", 64'(rel_adr[b_rel]), 64'd119);

      // two descriptors queued together
      b_iss = n_iss; b_word = n_word; b_rel = n_rel; b_err = n_err;
      push_desc(13'd200, 13'd202, 2'd1);
      push_desc(13'd1600, 13'd1601, 2'd2);
      wait_until(b_rel + 2, b_err + 1, "b2b");
      chk("b2b words", 64'(n_word - b_word), 64'd5);
      chk("b2b gap", 64'(iss_cyc[b_iss + 3] - iss_cyc[b_iss + 2]), 64'd3);
      for (int i = 0; i < 5; i++) begin
         a = (i < 3) ? 13'(200 + i) : 13'(1600 + i - 3);
         w = words[b_word + i];
         chk($sformatf("b2b data%0d", i), 64'(w.d), 64'(pat(a)));
         chk($sformatf("b2b flags%0d", i), 64'({w.sof, w.eof, w.lb}),
             64'({(i == 0) || (i == 3), (i == 2) || (i == 4),
                  (i == 2) ? 2'd1 : ((i == 4) ? 2'd2 : 2'd0)}));
      end
      chk("b2b rel A", 64'({rel_rgn[b_rel], rel_adr[b_rel]}), 64'({2'd0, 13'd202}));
      chk("b2b rel B", 64'({rel_rgn[b_rel + 1], rel_adr[b_rel + 1]}), 64'({2'd1, 13'd1601}));

      // reset in the middle of a frame
      b_iss = n_iss; b_rel = n_rel;
      bus.i_ready = 1'b0;
      push_desc(13'd400, 13'd419, 2'd0);
      for (int t = 0; t < 50 && (n_iss - b_iss) < 3; t++) tick(1);
      chk("mid reads started", 64'(n_iss - b_iss >= 3), 64'd1);
      i_reset = 1'b1;
      tick(1);
      chk("rst valid", 64'(bus.o_valid), 64'd0);
      i_reset = 1'b0;
      bus.i_ready = 1'b1;
      b_iss = n_iss;
      tick(20);
      chk("rst state", 64'(dut.r_state), 64'(ST_IDLE));
      chk("rst no reads", 64'(n_iss - b_iss), 64'd0);
      chk("rst no release", 64'(n_rel - b_rel), 64'd0);
      chk("rst idle valid", 64'(bus.o_valid), 64'd0);

      b_word = n_word; b_rel = n_rel; b_err = n_err;
      push_desc(13'd10, 13'd11, 2'd3);
      wait_until(b_rel + 1, b_err + 1, "post rst");
      chk("post rst words", 64'(n_word - b_word), 64'd2);
      chk("post rst first", 64'({words[b_word].d, words[b_word].sof}), 64'({pat(13'd10), 1'b1}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/mem_frame_reader.md
Name: mem_frame_reader

Overview:
- Read side of the 3-region shared packet SRAM bank.
- Pops frame descriptors {extra_byte, end_adr, start_adr} from the descriptor FIFO filled by the bank writer, then drives the SRAM read address/enable.
- Streams the frame's 32-bit words to the egress port with sof/eof/byte-count and ready/valid backpressure.
- Releases each region's space back to flow control after the last word has been read.

Parameters:
- pDEPTH_RAM, 4608, SRAM depth in 32-bit words.
- pADDR_W, $clog2(pDEPTH_RAM), address width (13).
- pRD_LAT, 2, cycles from o_en_read asserted to i_mem_data valid (1 bank input register + 1 SRAM read).
- pSKID, 4, output skid FIFO depth; must be ≥ pRD_LAT+1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_fifo_empty  in  1  descriptor FIFO empty.
- o_fifo_rd  out  1  descriptor pop; i_fifo_data is valid the following cycle.
- i_fifo_data  in  2*pADDR_W+2  {extra[1:0], end_adr, start_adr}.
- o_adr_out  out  pADDR_W  SRAM read address.
- o_en_read  out  1  SRAM read enable.
- i_mem_data  in  32  SRAM read data.
- o_data  out  32  egress word.
- o_valid  out  1  egress word valid.
- i_ready  in  1  egress accept.
- o_sof  out  1  first word of frame (qualified by o_valid).
- o_eof  out  1  last word of frame (qualified by o_valid).
- o_last_bytes  out  2  valid bytes in the eof word; 0 = 4 bytes.
- o_rel_valid  out  1  one-cycle region release pulse.
- o_rel_region  out  2  region 0/1/2 being released.
- o_rel_adr  out  pADDR_W  last address freed (end_adr).
- o_err  out  1  one-cycle pulse on a malformed descriptor.

Behaviour:
- Regions:
  - R0 = 0..1534.
  - R1 = 1535..3070.
  - R2 = 3071..pDEPTH_RAM-1.
  - Region is decoded from start_adr.
- Reset: all outputs 0, FSM in IDLE, skid FIFO and outstanding counter cleared, pipeline valid bits cleared. A reset mid-frame discards the in-flight frame and its descriptor; no release pulse is issued.
- FSM states:
  - IDLE: if !i_fifo_empty, go to POP.
  - POP: o_fifo_rd=1 for exactly one cycle, then LOAD.
  - LOAD: capture descriptor; compute region; set cur=start_adr, first=1.
    - If end_adr lies outside the region of start_adr: pulse o_err, drop the descriptor, go to IDLE.
    - Otherwise go to READ.
  - READ: each cycle with credit, issue o_en_read=1 and o_adr_out=cur. Tag the slot with sof=first and eof=(cur==end_adr).
    - Advance cur: cur==region_top → region_base, else cur+1. Clear first.
    - With no credit: o_en_read=0 and cur holds.
    - After issuing the eof address: go to POP if !i_fifo_empty, else IDLE. Frames issue back-to-back without a bubble beyond POP/LOAD.
- Credit rule: issue only when (outstanding + skid_count) < pSKID.
  - outstanding counts issued reads whose data has not yet entered the skid FIFO.
  - Simultaneous issue and arrival net to zero change.
- Tag pipeline: {sof, eof, extra} shift register of depth pRD_LAT aligned with i_mem_data. On arrival, push {data, sof, eof, extra} into the skid FIFO.
- Egress: o_valid = skid not empty; a word is popped when o_valid && i_ready. Data and flags hold while i_ready=0.
  - o_last_bytes = extra on the eof word, 0 otherwise.
  - Word ordering is strictly preserved.
- Release: when the eof word pops on egress, pulse o_rel_valid with that frame's region and end_adr.
- Single-word frame (start==end): one read, with sof and eof both set on the same word.
- Wrap: a frame crossing region_top reads top, then base, and continues up to end.
- Frame length is (end-start) mod region_size + 1 words.

Decomposition:
- Shared package, common to the writer and reader:
  - region base/top constants (0/1534, 1535/3070, 3071/pDEPTH_RAM-1);
  - descriptor field offsets and width;
  - FSM state enum.
- One sub-module, mem_rd_skid_fifo: synchronous FIFO, depth pSKID, width 32+2+2, with count output, push/pop, and flush on i_reset.

Test Plan:
- Descriptor {2'd0, 13'd9, 13'd5}, i_ready=1 → addresses 5..9 issued on consecutive cycles; 5 egress words with sof on the adr 5 word, eof on the adr 9 word, o_last_bytes=0; one o_rel_valid with region 0, adr 9.
- R1 wrap, descriptor {2'd3, 13'd1536, 13'd3069} → addresses 3069, 3070, 1535, 1536; eof word has o_last_bytes=3; release region 1.
- Single word {2'd1, 13'd3071, 13'd3071} → one read; sof=eof=1 on one word; release region 2.
- Backpressure: 20-word frame with i_ready=0 for 10 cycles mid-frame → no more than pSKID reads outstanding plus buffered; no word lost or duplicated; o_data held stable while stalled.
- Two queued descriptors → second frame's POP follows the first frame's eof issue; egress order frame A then frame B, with sof/eof correct for each.
- Malformed {0, 13'd2000, 13'd10} → o_err pulse, no reads issued, no release; reset asserted mid-frame → o_valid=0 next cycle and FSM returns to IDLE.
